// File: rtl/spi_host_pkg.sv
// Shared types and header layout for the SPI host transaction engine.
// Optional echo checking in the top level is enabled by SPI_HOST_ECHO_CHECK_EN.
package spi_host_pkg;

    localparam int WORD_BITS    = 32;
    localparam int HDR_OP_BIT   = 31;
    localparam int HDR_ADDR_MSB = 30;
    localparam int HDR_ADDR_LSB = 16;
    localparam int HDR_LEN_MSB  = 9;
    localparam int HDR_LEN_LSB  = 0;
    localparam int CNT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_LO,
        ST_HDR,
        ST_ECHO,
        ST_DATA,
        ST_FINISH
    } host_state_e;

    typedef enum logic [2:0] {
        SH_IDLE,
        SH_CS_GAP,
        SH_WAIT_WORD,
        SH_LOW,
        SH_HIGH,
        SH_TAIL_GAP,
        SH_CS_HI_GAP
    } shift_state_e;

    // The slave expects len-1 in the low field so that 512 words fit in 9+1 bits.
    function automatic logic [WORD_BITS-1:0] make_header(input logic        wr,
                                                         input logic [14:0] addr,
                                                         input logic [9:0]  len);
        logic [WORD_BITS-1:0] h;
        h = '0;
        h[HDR_OP_BIT]                = wr;
        h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        h[HDR_LEN_MSB:HDR_LEN_LSB]   = len - 10'd1;
        return h;
    endfunction

endpackage

// File: rtl/spi_host_shifter.sv
// Single SPI frame engine: chip-select gaps, sclk divider and 32-bit shift in/out.
// A frame carries frame_words_i words; zero words gives a bare cs_n low/high pulse.
module spi_host_shifter
    import spi_host_pkg::*;
#(
    parameter int HALF_DIV = 8,
    parameter int GAP_CYC  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start_i,
    input  logic [9:0]           frame_words_i,
    output logic                 word_req_o,
    input  logic                 word_valid_i,
    input  logic [WORD_BITS-1:0] word_data_i,
    output logic                 word_done_o,
    output logic [WORD_BITS-1:0] rx_word_o,
    output logic                 frame_done_o,
    output logic                 cs_n_o,
    output logic                 sclk_o,
    output logic                 mosi_o,
    input  logic                 miso_i
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    shift_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [9:0]           words_left_q, words_left_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [WORD_BITS-1:0] rx_q, rx_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 word_done_q, word_done_d;
    logic                 frame_done_q, frame_done_d;
    logic                 miso_meta_q, miso_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SH_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            words_left_q <= '0;
            shift_q      <= '0;
            rx_q         <= '0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            word_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            miso_meta_q  <= 1'b0;
            miso_sync_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            words_left_q <= words_left_d;
            shift_q      <= shift_d;
            rx_q         <= rx_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            word_done_q  <= word_done_d;
            frame_done_q <= frame_done_d;
            miso_meta_q  <= miso_i;
            miso_sync_q  <= miso_meta_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        words_left_d = words_left_q;
        shift_d      = shift_q;
        rx_d         = rx_q;
        cs_n_d       = cs_n_q;
        sclk_d       = sclk_q;
        word_done_d  = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            SH_IDLE: begin
                if (frame_start_i) begin
                    cs_n_d       = 1'b0;
                    cnt_d        = '0;
                    words_left_d = frame_words_i;
                    state_d      = SH_CS_GAP;
                end
            end
            SH_CS_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (words_left_q == 10'd0) ? SH_TAIL_GAP : SH_WAIT_WORD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SH_WAIT_WORD: begin
                // Stalling here keeps sclk low and cs_n low, so no bit is lost.
                if (word_valid_i) begin
                    shift_d   = word_data_i;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    state_d   = SH_LOW;
                end
            end
            SH_LOW: begin
                if (cnt_q == HALF_LAST) begin
                    sclk_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SH_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SH_HIGH: begin
                if (cnt_q == HALF_LAST) begin
                    sclk_d    = 1'b0;
                    cnt_d     = '0;
                    rx_d      = {rx_q[WORD_BITS-2:0], miso_sync_q};
                    shift_d   = {shift_q[WORD_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        word_done_d  = 1'b1;
                        words_left_d = words_left_q - 10'd1;
                        state_d      = (words_left_q == 10'd1) ? SH_TAIL_GAP : SH_WAIT_WORD;
                    end else begin
                        state_d = SH_LOW;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SH_TAIL_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cs_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SH_CS_HI_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SH_CS_HI_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = SH_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SH_IDLE;
        endcase
    end

    assign word_req_o   = (state_q == SH_WAIT_WORD);
    assign word_done_o  = word_done_q;
    assign frame_done_o = frame_done_q;
    assign rx_word_o    = rx_q;
    assign cs_n_o       = cs_n_q;
    assign sclk_o       = sclk_q;
    // Consumed bits are replaced by zeros, so MOSI rests low between words.
    assign mosi_o       = shift_q[WORD_BITS-1];

endmodule

// File: rtl/spi_host_master.sv
// SPI host transaction engine: spi_reset pulse, header, echo and data frames.
// Define SPI_HOST_ECHO_CHECK_EN to compare the echoed header and abort DATA on mismatch.
module spi_host_master
    import spi_host_pkg::*;
#(
    parameter int HALF_DIV  = 8,
    parameter int GAP_CYC   = 16,
    parameter int RST_CYC   = 16,
    parameter int MAX_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr,
    input  logic [14:0] addr,
    input  logic [9:0]  len,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        spi_reset,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    host_state_e          state_q, state_d;
    logic                 wr_q, wr_d;
    logic [14:0]          addr_q, addr_d;
    logic [9:0]           len_q, len_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 gap_phase_q, gap_phase_d;
    logic                 spi_reset_q, spi_reset_d;
    logic                 err_q, err_d;
    logic [31:0]          rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;

    logic                 frame_start;
    logic [9:0]           frame_words;
    logic                 word_req;
    logic                 word_valid;
    logic [WORD_BITS-1:0] word_data;
    logic                 word_done;
    logic [WORD_BITS-1:0] rx_word;
    logic                 frame_done;
    logic [WORD_BITS-1:0] header;
    logic                 len_bad;
    logic                 echo_bad;

    assign header  = make_header(wr_q, addr_q, len_q);
    assign len_bad = (len == 10'd0) || (len > 10'(MAX_WORDS));

`ifdef SPI_HOST_ECHO_CHECK_EN
    assign echo_bad = (rx_word != header);
`else
    assign echo_bad = 1'b0;
`endif

    spi_host_shifter #(
        .HALF_DIV (HALF_DIV),
        .GAP_CYC  (GAP_CYC)
    ) u_shifter (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start),
        .frame_words_i (frame_words),
        .word_req_o    (word_req),
        .word_valid_i  (word_valid),
        .word_data_i   (word_data),
        .word_done_o   (word_done),
        .rx_word_o     (rx_word),
        .frame_done_o  (frame_done),
        .cs_n_o        (cs_n),
        .sclk_o        (sclk),
        .mosi_o        (mosi),
        .miso_i        (miso)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            gap_phase_q <= 1'b0;
            spi_reset_q <= 1'b1;
            err_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            gap_phase_q <= gap_phase_d;
            spi_reset_q <= spi_reset_d;
            err_q       <= err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        gap_phase_d = gap_phase_q;
        spi_reset_d = spi_reset_q;
        err_d       = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_start = 1'b0;
        frame_words = '0;
        word_valid  = 1'b0;
        word_data   = '0;
        tx_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        wr_d        = wr;
                        addr_d      = addr;
                        len_d       = len;
                        cnt_d       = '0;
                        gap_phase_d = 1'b0;
                        spi_reset_d = 1'b0;
                        state_d     = ST_START_LO;
                    end
                end
            end
            ST_START_LO: begin
                // Low pulse first, then a gap before the header frame drops cs_n.
                if (!gap_phase_q) begin
                    if (cnt_q == RST_LAST) begin
                        spi_reset_d = 1'b1;
                        gap_phase_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d       = '0;
                    frame_start = 1'b1;
                    frame_words = 10'd1;
                    state_d     = ST_HDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HDR: begin
                word_valid = 1'b1;
                word_data  = header;
                if (frame_done) begin
                    frame_start = 1'b1;
                    frame_words = 10'd1;
                    state_d     = ST_ECHO;
                end
            end
            ST_ECHO: begin
                word_valid = 1'b1;
                if (frame_done) begin
                    // A failed echo still runs an empty DATA frame so the slave sees cs_n rise.
                    err_d       = echo_bad;
                    frame_start = 1'b1;
                    frame_words = echo_bad ? 10'd0 : len_q;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (wr_q) begin
                    tx_ready   = word_req;
                    word_valid = tx_valid;
                    word_data  = tx_data;
                end else begin
                    word_valid = 1'b1;
                    if (word_done) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_word;
                    end
                end
                if (frame_done) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done      = (state_q == ST_FINISH);
    assign err       = err_q;
    assign spi_reset = spi_reset_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master with a behavioural SPI slave (header, echo, RAM data frames).
// Echo-corruption behaviour is checked against SPI_HOST_ECHO_CHECK_EN when it is defined.
module tb_spi_host_master;

    localparam int HALF_DIV  = 8;
    localparam int GAP_CYC   = 16;
    localparam int RST_CYC   = 16;
    localparam int MAX_WORDS = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        wr = 1'b0;
    logic [14:0] addr = '0;
    logic [9:0]  len = '0;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        done;
    logic        err;
    logic        spi_reset;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_host_master #(
        .HALF_DIV (HALF_DIV),
        .GAP_CYC  (GAP_CYC),
        .RST_CYC  (RST_CYC),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wr        (wr),
        .addr      (addr),
        .len       (len),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .spi_reset (spi_reset),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso)
    );

    // ---------------- behavioural slave ----------------
    int          sl_frame = -1;
    int          sl_bit = 0;
    int          sl_word = 0;
    logic [31:0] sl_in = '0;
    logic [31:0] sl_out = '0;
    logic [31:0] sl_hdr = '0;
    logic [31:0] ram [0:511];
    bit          corrupt_echo = 1'b0;
    logic [31:0] hdr_q[$];
    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          data_sclk_rises = 0;

    function automatic logic [31:0] slave_word(input int frame, input int k);
        if (frame == 1) return sl_hdr ^ (corrupt_echo ? 32'h0000_0020 : 32'h0);
        if (frame == 2 && !sl_hdr[31] && k < 512) return ram[k];
        return 32'h0;
    endfunction

    always @(negedge spi_reset) sl_frame = -1;

    always @(negedge cs_n) begin
        sl_frame = sl_frame + 1;
        sl_bit   = 0;
        sl_word  = 0;
        sl_out   = slave_word(sl_frame, 0);
        miso     = sl_out[31];
    end

    always @(posedge sclk) begin
        if (sl_frame == 2) data_sclk_rises++;
        sl_in  = {sl_in[30:0], mosi};
        sl_bit = sl_bit + 1;
        if (sl_bit == 32) begin
            if (sl_frame == 0) begin
                sl_hdr = sl_in;
                hdr_q.push_back(sl_in);
            end else if (sl_frame == 2 && sl_hdr[31]) begin
                wa_q.push_back(sl_word);
                wd_q.push_back(sl_in);
            end
            sl_bit  = 0;
            sl_word = sl_word + 1;
        end
    end

    always @(negedge sclk) begin
        if (cs_n === 1'b0) begin
            if (sl_bit == 0) sl_out = slave_word(sl_frame, sl_word);
            else             sl_out = {sl_out[30:0], 1'b0};
            miso = sl_out[31];
        end
    end

    // ---------------- output monitor ----------------
    logic [31:0] rx_got[$];
    int   done_cnt = 0, err_cnt = 0, busy_cnt = 0, sr_fall_cnt = 0, cs_fall_cnt = 0;
    logic sr_prev = 1'b1, cs_prev = 1'b1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_got.push_back(rx_data);
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (sr_prev === 1'b1 && spi_reset === 1'b0) sr_fall_cnt++;
        if (cs_prev === 1'b1 && cs_n === 1'b0) cs_fall_cnt++;
        sr_prev = spi_reset;
        cs_prev = cs_n;
    end

    // ---------------- write-word source ----------------
    logic [31:0] tx_q[$];
    int          tx_idx = 0;
    bit          tx_stall = 1'b0;
    bit          xfer_pend = 1'b0;

    always @(negedge clk) begin
        if (xfer_pend) tx_idx++;
        tx_valid  = !tx_stall && (tx_idx < tx_q.size());
        tx_data   = (tx_idx < tx_q.size()) ? tx_q[tx_idx] : 32'h0;
        xfer_pend = tx_valid && (tx_ready === 1'b1);
    end

    // ---------------- helpers ----------------
    typedef struct {
        logic             wr;
        logic [14:0]      addr;
        logic [9:0]       len;
        logic [3:0][31:0] data;
        logic             exp_err;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rx_got.delete();
        hdr_q.delete();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        sr_fall_cnt = 0; cs_fall_cnt = 0; data_sclk_rises = 0;
    endtask

    task automatic pulse_start(input logic w, input logic [14:0] a, input logic [9:0] l);
        wr = w; addr = a; len = l; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget && done_cnt == 0; c++) tick();
        repeat (20) tick();
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] exp_hdr;
        int          n;
        n = int'(v.len);
        clear_mon();
        tx_q.delete();
        tx_idx = 0;
        for (int k = 0; k < n && k < 4; k++) begin
            if (v.wr) tx_q.push_back(v.data[k]);
            else      ram[k] = v.data[k];
        end
        $display("txn %s wr=%0d addr=%h len=%0d", tag, v.wr, v.addr, v.len);
        pulse_start(v.wr, v.addr, v.len);
        if (v.exp_err) begin
            repeat (60) tick();
            check({tag, "_err_pulse"}, err_cnt, 1);
            check({tag, "_busy_cycles"}, busy_cnt, 0);
            check({tag, "_spi_activity"}, sr_fall_cnt + cs_fall_cnt, 0);
            return;
        end
        // A second start while busy, with an invalid length, must be ignored entirely.
        repeat (100) tick();
        pulse_start(1'b0, 15'h0, 10'd0);
        wait_done(20000);
        exp_hdr = {v.wr, v.addr, 6'b0, v.len - 10'd1};
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_spi_reset_falls"}, sr_fall_cnt, 1);
        check({tag, "_cs_falls"}, cs_fall_cnt, 3);
        check({tag, "_busy_end"}, {31'b0, busy}, 0);
        check({tag, "_hdr_cnt"}, hdr_q.size(), 1);
        if (hdr_q.size() > 0) check({tag, "_header"}, hdr_q[0], exp_hdr);
        if (v.wr) begin
            check({tag, "_wr_cnt"}, wa_q.size(), n);
            for (int k = 0; k < wa_q.size() && k < n; k++) begin
                check({tag, "_wr_addr"}, wa_q[k], k);
                check({tag, "_wr_data"}, wd_q[k], v.data[k]);
            end
        end else begin
            check({tag, "_rx_cnt"}, rx_got.size(), n);
            for (int k = 0; k < rx_got.size() && k < n; k++)
                check({tag, "_rx_data"}, rx_got[k], v.data[k]);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t v;
        int   bad;

        for (int i = 0; i < 512; i++) ram[i] = '0;

        tbl[0] = '{wr: 1'b1, addr: 15'h0012, len: 10'd2,
                   data: {32'h0, 32'h0, 32'h5A5A_0002, 32'hA5A5_0001}, exp_err: 1'b0};
        tbl[1] = '{wr: 1'b0, addr: 15'h0100, len: 10'd3,
                   data: {32'h0, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, exp_err: 1'b0};
        tbl[2] = '{wr: 1'b0, addr: 15'h0001, len: 10'd0,   data: '0, exp_err: 1'b1};
        tbl[3] = '{wr: 1'b1, addr: 15'h0002, len: 10'd513, data: '0, exp_err: 1'b1};
        tbl[4] = '{wr: 1'b0, addr: 15'h7FFF, len: 10'd1023, data: '0, exp_err: 1'b1};

        repeat (5) tick();
        check("rst_spi_reset", {31'b0, spi_reset}, 1);
        check("rst_cs_n",      {31'b0, cs_n}, 1);
        check("rst_sclk",      {31'b0, sclk}, 0);
        check("rst_mosi",      {31'b0, mosi}, 0);
        check("rst_tx_ready",  {31'b0, tx_ready}, 0);
        check("rst_rx_valid",  {31'b0, rx_valid}, 0);
        check("rst_busy",      {31'b0, busy}, 0);
        check("rst_done",      {31'b0, done}, 0);
        check("rst_err",       {31'b0, err}, 0);
        check("rst_rx_data",   rx_data, 32'h0);
        rst = 1'b0;
        repeat (5) tick();

        for (int i = 0; i < 5; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            v.wr      = 1'($urandom_range(0, 1));
            v.addr    = 15'($urandom);
            v.len     = 10'($urandom_range(1, 4));
            v.exp_err = 1'b0;
            for (int k = 0; k < 4; k++) v.data[k] = $urandom;
            run_txn(v, $sformatf("rnd%0d", i));
        end

        // Write with tx_valid withheld for 200 cycles once DATA asks for a word.
        $display("txn stall wr=1 addr=0040 len=1");
        clear_mon();
        tx_q.delete();
        tx_q.push_back(32'hC3C3_1234);
        tx_idx = 0;
        tx_stall = 1'b1;
        pulse_start(1'b1, 15'h0040, 10'd1);
        for (int c = 0; c < 5000 && tx_ready !== 1'b1; c++) tick();
        check("stall_reach_data", {31'b0, tx_ready}, 1);
        bad = 0;
        repeat (200) begin
            tick();
            if (sclk !== 1'b0 || cs_n !== 1'b0) bad++;
        end
        check("stall_lines_held", bad, 0);
        tx_stall = 1'b0;
        wait_done(5000);
        check("stall_done", done_cnt, 1);
        check("stall_wr_cnt", wa_q.size(), 1);
        if (wd_q.size() > 0) begin
            check("stall_wr_addr", wa_q[0], 0);
            check("stall_wr_data", wd_q[0], 32'hC3C3_1234);
        end

        // Reset in the middle of a 4-word read, then a clean 1-word read.
        $display("txn rst_mid wr=0 addr=0200 len=4");
        clear_mon();
        for (int k = 0; k < 4; k++) ram[k] = $urandom;
        pulse_start(1'b0, 15'h0200, 10'd4);
        for (int c = 0; c < 10000 && rx_got.size() == 0; c++) tick();
        check("rstmid_first_word_cnt", rx_got.size(), 1);
        if (rx_got.size() > 0) check("rstmid_first_word", rx_got[0], ram[0]);
        repeat (137) tick();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_cs_n",      {31'b0, cs_n}, 1);
        check("rstmid_sclk",      {31'b0, sclk}, 0);
        check("rstmid_spi_reset", {31'b0, spi_reset}, 1);
        check("rstmid_busy",      {31'b0, busy}, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        v.wr = 1'b0; v.addr = 15'h0201; v.len = 10'd1; v.exp_err = 1'b0;
        v.data = '0;
        v.data[0] = 32'hDEAD_BEEF;
        run_txn(v, "post_rst");

`ifdef SPI_HOST_ECHO_CHECK_EN
        $display("txn echo_bad wr=0 addr=0033 len=2");
        clear_mon();
        corrupt_echo = 1'b1;
        pulse_start(1'b0, 15'h0033, 10'd2);
        wait_done(10000);
        corrupt_echo = 1'b0;
        check("echo_err_cnt", err_cnt, 1);
        check("echo_done_cnt", done_cnt, 1);
        check("echo_rx_cnt", rx_got.size(), 0);
        check("echo_data_sclk", data_sclk_rises, 0);
        check("echo_cs_falls", cs_fall_cnt, 3);
`else
        corrupt_echo = 1'b1;
        v.wr = 1'b0; v.addr = 15'h0033; v.len = 10'd1; v.exp_err = 1'b0;
        v.data = '0;
        v.data[0] = 32'h0BAD_ECC0;
        run_txn(v, "echo_ignored");
        corrupt_echo = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_host_master.md
Name: spi_host_master

Overview:
- SPI host-side transaction engine that drives the board-level SPI slave register/RAM bridge.
- Generates the full slave protocol: a `spi_reset` start pulse, a header frame, a check/echo frame and a data frame.
- Streams write words out on MOSI, and returns read words captured from MISO.
- Sits directly upstream of the slave: its `spi_reset`, `cs_n`, `sclk` and `mosi` outputs drive the slave's inputs, and it takes the slave's `miso`.

Parameters:
- `HALF_DIV`, 8: `clk` cycles per `sclk` half-period. Minimum 4, so the slave's 2-flop sync plus edge detect settles.
- `GAP_CYC`, 16: `clk` cycles inserted between any two `spi_reset`/`cs_n` edges.
- `RST_CYC`, 16: cycles `spi_reset` is held low before the header frame. `spi_reset` idles high; its falling edge starts a transaction.
- `MAX_WORDS`, 512: maximum data words per transaction (slave address is 9 bits).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `wr` in 1: 1 = write transaction, 0 = read transaction.
- `addr` in 15: slave base address.
- `len` in 10: word count, 1..`MAX_WORDS`.
- `tx_data` in 32: write word.
- `tx_valid` in 1: write word available.
- `tx_ready` out 1: master accepts `tx_data` this cycle.
- `rx_data` out 32: read word.
- `rx_valid` out 1: one-cycle pulse, `rx_data` valid. No backpressure.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse on bad `len` or echo mismatch.
- `spi_reset` out 1: slave start control.
- `cs_n` out 1: chip select.
- `sclk` out 1: serial clock.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in, asynchronous to `clk`; 2-flop synchronised internally.

Behaviour:
- Reset values:
  - `spi_reset`=1, `cs_n`=1, `sclk`=0, `mosi`=0.
  - `tx_ready`/`rx_valid`/`done`/`err`/`busy`=0, `rx_data`=0.
- Reset mid-operation returns all outputs to these values on the next `clk` and the FSM to IDLE. The slave recovers on the next `spi_reset` falling edge, because its FSM returns to IDLE on `cs_n` rise or is restarted.
- `start` with `len`==0 or `len`>`MAX_WORDS`: ignored, `err` pulses 1 cycle, `busy` stays 0.
- Valid `start`: latch `wr`/`addr`/`len`; `busy`=1.
- FSM states: IDLE → START_LO → HDR → ECHO → DATA → FINISH → IDLE.
  - START_LO: `spi_reset`=0 for `RST_CYC`, then 1, wait `GAP_CYC`.
  - HDR: one frame of 1 word, header = {`wr`, `addr`, 6'b0, `len`-1}.
  - ECHO: one frame of 1 word; MOSI=0, MISO captured.
  - DATA: one frame of `len` words.
  - FINISH: `done` pulse, `busy`=0.
- Frame timing:
  - `cs_n`=0, wait `GAP_CYC`.
  - Per bit, MSB first: drive `mosi`, `sclk` low `HALF_DIV`, `sclk` high `HALF_DIV`.
  - Sample synchronised `miso` in the last `clk` of the high half.
  - After the last bit: `sclk`=0, wait `GAP_CYC`, `cs_n`=1, wait `GAP_CYC`.
- Write DATA:
  - Before each word, assert `tx_ready`; transfer when `tx_valid`&&`tx_ready`.
  - If `tx_valid`=0, stall with `sclk` low and `cs_n` low indefinitely; no bits are lost.
  - Word k lands at slave RAM address k.
- Read DATA:
  - MOSI=0.
  - After bit 32 of each word, `rx_data`=assembled word and `rx_valid`=1 for 1 cycle.
  - Exactly `len` pulses.
- Bit counter 5-bit wraps at 32; word counter 10-bit compares to `len`.
- `start` while `busy`: ignored.

Optional Feature:
- Macro: `SPI_HOST_ECHO_CHECK_EN`.
- Defined: the word captured in ECHO is compared with the sent header.
  - On mismatch, `err` pulses at ECHO end.
  - The FSM skips DATA, still performs the DATA frame's `cs_n` low/high with zero `sclk` edges so the slave returns to IDLE, then pulses `done`.
- Undefined: ECHO capture is discarded; `err` arises only from bad `len`.

Decomposition:
- Package `spi_host_pkg`:
  - FSM state enum.
  - Header field positions: bit 31 opcode, [30:16] addr, [9:0] len-1.
  - `WORD_BITS`=32.
- Sub-module `spi_host_shifter`:
  - One frame engine: `cs_n` gap timing, `sclk` divider, 32-bit shift in/out.
  - Per-word `word_req`/`word_done` handshake.
  - Instantiated once; the top FSM sequences the frames.

Test Plan:
- Write, `addr`=0x0012, `len`=2, data 0xA5A5_0001 / 0x5A5A_0002 with a behavioural slave model → header 0x8012_0001 on MOSI; slave `wr_en` at `wr_addr` 0 and 1 with those data; one `done`.
- Read, `addr`=0x0100, `len`=3, slave RAM 0x11111111/0x22222222/0x33333333 → three `rx_valid` pulses with those values in order; `done` after the third.
- Write `len`=1 with `tx_valid` held low 200 cycles into DATA → `sclk` stays 0 and `cs_n` stays 0 for the stall; word then completes correctly.
- `len`=0 and `len`=513 → `err` pulse, no `spi_reset`/`cs_n` activity, `busy`=0.
- `rst` asserted mid-DATA of a 4-word read → next cycle `cs_n`=1, `sclk`=0, `spi_reset`=1; a following 1-word read returns correct data.
- With `SPI_HOST_ECHO_CHECK_EN`, slave model corrupts echo bit 5 → `err` pulse, no `sclk` in DATA, `done` pulse, no `rx_valid`.
